// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared types and constants for the rv bus arbiter
package rv_pkg;

  // Arbiter ownership states: the bus is either free or owned by one requester
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_FETCH = 2'd1,
    ARB_DATA  = 2'd2
  } arb_state_t;

  // All-ones byte-enable source, sliced down to the bus select width by users
  localparam logic [127:0] ARB_SEL_ALL = '1;

endpackage

// File: rtl/rv_bus_timeout.sv
// rtl/rv_bus_timeout.sv - per-transfer watchdog counter for the bus arbiter
module rv_bus_timeout #(
  parameter int TIMEOUT = 256
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clr,
  input  logic i_run,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] L_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Count waiting cycles of the current transfer; a new grant restarts from zero
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Expiry is reported while the count sits on its last value; the owner masks it
  assign o_expired = (r_cnt == L_LAST);

endmodule

// File: rtl/rv_bus_arb.sv
// rtl/rv_bus_arb.sv - fetch/data arbiter for one shared 32-bit system bus
module rv_bus_arb
  import rv_pkg::*;
#(
  parameter  int ADDR_W  = 32,
  parameter  int DATA_W  = 32,
  parameter  int TIMEOUT = 256,
  localparam int SEL_W   = DATA_W / 8
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_fetch_req,
  input  logic [ADDR_W-1:0] i_fetch_addr,
  output logic              o_fetch_ack,
  output logic              o_fetch_err,
  output logic [DATA_W-1:0] o_fetch_rdata,
  input  logic              i_data_req,
  input  logic              i_data_we,
  input  logic [ADDR_W-1:0] i_data_addr,
  input  logic [SEL_W-1:0]  i_data_sel,
  input  logic [DATA_W-1:0] i_data_wdata,
  output logic              o_data_ack,
  output logic              o_data_err,
  output logic [DATA_W-1:0] o_data_rdata,
  output logic              o_bus_cyc,
  output logic              o_bus_stb,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [SEL_W-1:0]  o_bus_sel,
  output logic [DATA_W-1:0] o_bus_wdata,
  input  logic              i_bus_ack,
  input  logic              i_bus_err,
  input  logic [DATA_W-1:0] i_bus_rdata
);

  localparam logic [SEL_W-1:0] L_SEL_ALL = ARB_SEL_ALL[SEL_W-1:0];

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              r_fair;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [SEL_W-1:0]  r_sel;
  logic [DATA_W-1:0] r_wdata;

  logic w_owned;
  logic w_expired;
  logic w_abort;
  logic w_done;
  logic w_can_grant;
  logic w_fetch_cand;
  logic w_data_cand;
  logic w_fair_now;
  logic w_grant_data;
  logic w_grant_fetch;
  logic w_bus_ack;
  logic w_resp_ack;
  logic w_resp_err;

  assign w_owned = (r_state != ARB_IDLE);

  // A timeout only aborts when the slave has not answered in that same cycle
  assign w_abort = w_owned & w_expired & ~i_bus_ack & ~i_bus_err;
  assign w_done  = w_owned & (i_bus_ack | i_bus_err | w_expired);

  // The finishing owner's request still belongs to the transfer just completed,
  // so it cannot re-win the bus on its own completion edge
  assign w_fetch_cand = i_fetch_req & (r_state != ARB_FETCH);
  assign w_data_cand  = i_data_req  & (r_state != ARB_DATA);

  // A data completion with fetch waiting raises fairness for this very decision
  assign w_fair_now = r_fair | ((r_state == ARB_DATA) & w_done & i_fetch_req);

  assign w_can_grant   = (r_state == ARB_IDLE) | w_done;
  assign w_grant_data  = w_can_grant & w_data_cand & ~(w_fair_now & w_fetch_cand);
  assign w_grant_fetch = w_can_grant & w_fetch_cand & ~w_grant_data;

  // Next-state selection: grant, fall back to idle on completion, else hold
  always_comb begin
    w_state_nxt = r_state;
    if (w_grant_data) begin
      w_state_nxt = ARB_DATA;
    end else if (w_grant_fetch) begin
      w_state_nxt = ARB_FETCH;
    end else if (w_can_grant) begin
      w_state_nxt = ARB_IDLE;
    end
  end

  // State register and fairness bit; a fetch grant clears fairness
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= ARB_IDLE;
      r_fair  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_fair  <= w_grant_fetch ? 1'b0 : w_fair_now;
    end
  end

  // Bus registers capture the winner's request only on the grant edge
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_sel   <= '0;
      r_wdata <= '0;
    end else if (w_grant_data) begin
      r_we    <= i_data_we;
      r_addr  <= i_data_addr;
      r_sel   <= i_data_sel;
      r_wdata <= i_data_wdata;
    end else if (w_grant_fetch) begin
      r_we    <= 1'b0;
      r_addr  <= i_fetch_addr;
      r_sel   <= L_SEL_ALL;
      r_wdata <= '0;
    end
  end

  rv_bus_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clr     (w_grant_data | w_grant_fetch),
    .i_run     (w_owned & ~i_bus_ack & ~i_bus_err),
    .o_expired (w_expired)
  );

  assign o_bus_cyc   = w_owned;
  assign o_bus_stb   = w_owned;
  assign o_bus_we    = r_we;
  assign o_bus_addr  = r_addr;
  assign o_bus_sel   = r_sel;
  assign o_bus_wdata = r_wdata;

  // Responses are suppressed while reset is asserted so an interrupted transfer stays silent
  assign w_bus_ack  = i_bus_ack & ~i_bus_err;
  assign w_resp_ack = i_reset_n & w_owned & w_bus_ack;
  assign w_resp_err = i_reset_n & ((w_owned & i_bus_err) | w_abort);

  assign o_fetch_ack   = (r_state == ARB_FETCH) & w_resp_ack;
  assign o_fetch_err   = (r_state == ARB_FETCH) & w_resp_err;
  assign o_fetch_rdata = o_fetch_ack ? i_bus_rdata : '0;
  assign o_data_ack    = (r_state == ARB_DATA) & w_resp_ack;
  assign o_data_err    = (r_state == ARB_DATA) & w_resp_err;
  assign o_data_rdata  = o_data_ack ? i_bus_rdata : '0;

endmodule
